// File: rtl/writeback_queue_if.sv
// writeback_queue_if -- signal bundle for the writeback queue.
//   Source A  : a_valid/a_ready/a_sel/a_dat (in-order pipeline result)
//   Source B  : b_valid/b_ready/b_sel/b_dat (long-latency mul/div result)
//   RF port   : drain_en in, WEN/wsel/wdat out
//   Lookup    : rsel1/rsel2 in, hit1/hit2/hdat1/hdat2 out
// Modport slave is the queue itself; master is the surrounding pipeline.
interface writeback_queue_if;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_sel;
    logic [31:0] a_dat;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_sel;
    logic [31:0] b_dat;
    logic        drain_en;
    logic        WEN;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic [4:0]  rsel1;
    logic [4:0]  rsel2;
    logic        hit1;
    logic        hit2;
    logic [31:0] hdat1;
    logic [31:0] hdat2;

    modport master (
        output a_valid, a_sel, a_dat, b_valid, b_sel, b_dat, drain_en, rsel1, rsel2,
        input  a_ready, b_ready, WEN, wsel, wdat, hit1, hit2, hdat1, hdat2
    );

    modport slave (
        input  a_valid, a_sel, a_dat, b_valid, b_sel, b_dat, drain_en, rsel1, rsel2,
        output a_ready, b_ready, WEN, wsel, wdat, hit1, hit2, hdat1, hdat2
    );
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue -- merges two register-file write sources into a circular
// pending-write FIFO that drains through the single RF write port, and offers
// a two-port lookup so decode can detect (and optionally forward) pending writes.
// Ports:
//   CLK   : clock, all state updates on rising edge
//   nRST  : asynchronous active-low reset
//   bus   : writeback_queue_if.slave (A/B sources, RF write port, lookup)
// Build option: define WB_FORWARD_EN to drive hdat1/hdat2 with forwarded data;
// without it hdat1/hdat2 are tied to 0 and only hit1/hit2 are produced.
module writeback_queue #(
    parameter int unsigned DEPTH = 4
) (
    input logic             CLK,
    input logic             nRST,
    writeback_queue_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CntDm1 = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CntDm2 = CW'(DEPTH - 2);

    logic [4:0]    sel_q [DEPTH];
    logic [31:0]   dat_q [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;

    logic          nonempty, pop, push_a, push_b;
    logic [AW-1:0] b_slot;

    // Readiness depends only on registered count (plus a_valid for B priority).
    assign bus.a_ready = (count_q <= CntDm1);
    assign bus.b_ready = (count_q <= CntDm2) || (!bus.a_valid && (count_q <= CntDm1));

    assign nonempty = (count_q != '0);
    assign pop      = bus.drain_en && nonempty;
    assign bus.WEN  = pop;
    // Popped slots keep stale contents, so gate the head with nonempty.
    assign bus.wsel = nonempty ? sel_q[head_q] : '0;
    assign bus.wdat = nonempty ? dat_q[head_q] : '0;

    // Writes to r0 complete the handshake but are dropped.
    assign push_a  = bus.a_valid && bus.a_ready && (bus.a_sel != '0);
    assign push_b  = bus.b_valid && bus.b_ready && (bus.b_sel != '0);
    // B lands behind A when both are stored this cycle, keeping A older.
    assign b_slot  = push_a ? tail_q + AW'(1) : tail_q;
    assign count_d = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sel_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            if (push_a) begin
                sel_q[tail_q] <= bus.a_sel;
                dat_q[tail_q] <= bus.a_dat;
            end
            if (push_b) begin
                sel_q[b_slot] <= bus.b_sel;
                dat_q[b_slot] <= bus.b_dat;
            end
            head_q  <= head_q + AW'(pop);
            tail_q  <= tail_q + AW'(push_a) + AW'(push_b);
            count_q <= count_d;
        end
    end

    // Lookup walks oldest to youngest so the last match wins (youngest data).
    // Only registered entries are searched; same-cycle enqueues are invisible,
    // while the head being popped still matches.
    logic          hit1, hit2;
    logic [AW-1:0] idx;
`ifdef WB_FORWARD_EN
    logic [31:0]   hd1, hd2;
`endif

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        idx  = head_q;
`ifdef WB_FORWARD_EN
        hd1  = '0;
        hd2  = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + AW'(k);
            if (CW'(k) < count_q) begin
                if ((bus.rsel1 != '0) && (sel_q[idx] == bus.rsel1)) begin
                    hit1 = 1'b1;
`ifdef WB_FORWARD_EN
                    hd1  = dat_q[idx];
`endif
                end
                if ((bus.rsel2 != '0) && (sel_q[idx] == bus.rsel2)) begin
                    hit2 = 1'b1;
`ifdef WB_FORWARD_EN
                    hd2  = dat_q[idx];
`endif
                end
            end
        end
    end

    assign bus.hit1 = hit1;
    assign bus.hit2 = hit2;
`ifdef WB_FORWARD_EN
    assign bus.hdat1 = hd1;
    assign bus.hdat2 = hd2;
`else
    assign bus.hdat1 = '0;
    assign bus.hdat2 = '0;
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue -- directed bench for writeback_queue (DEPTH = 4).
// A queue-based reference model predicts every output each cycle; directed
// scenarios add literal expectations for single write, dual enqueue, fill,
// r0 drop, mid-operation reset and pointer wrap.
module tb_writeback_queue;
    localparam int D = 4;

    logic CLK;
    logic nRST;
    writeback_queue_if bus ();

    writeback_queue #(.DEPTH(D)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        CLK = 1'b0;
        forever #10 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [4:0]  msel[$];
    logic [31:0] mdat[$];
    logic [4:0]  nsel[$];
    logic [31:0] ndat[$];
    bit          pend;
    int          n;
    logic        e_ar, e_br, e_wen, e_h1, e_h2;
    logic [4:0]  e_wsel;
    logic [31:0] e_wdat, e_hd1, e_hd2;

    always @(negedge nRST) begin
        msel.delete();
        mdat.delete();
        pend = 1'b0;
    end

    always @(negedge CLK) begin
        n      = msel.size();
        e_ar   = (n <= D - 1);
        e_br   = (n <= D - 2) || (!bus.a_valid && n <= D - 1);
        e_wen  = bus.drain_en && (n != 0);
        e_wsel = (n != 0) ? msel[0] : 5'd0;
        e_wdat = (n != 0) ? mdat[0] : 32'd0;
        e_h1 = 1'b0; e_h2 = 1'b0; e_hd1 = 32'd0; e_hd2 = 32'd0;
        for (int j = 0; j < n; j++) begin
            if (bus.rsel1 != 5'd0 && msel[j] == bus.rsel1) begin e_h1 = 1'b1; e_hd1 = mdat[j]; end
            if (bus.rsel2 != 5'd0 && msel[j] == bus.rsel2) begin e_h2 = 1'b1; e_hd2 = mdat[j]; end
        end
`ifndef WB_FORWARD_EN
        e_hd1 = 32'd0;
        e_hd2 = 32'd0;
`endif
        chk("m_a_ready", 32'(bus.a_ready), 32'(e_ar));
        chk("m_b_ready", 32'(bus.b_ready), 32'(e_br));
        chk("m_WEN",     32'(bus.WEN),     32'(e_wen));
        chk("m_wsel",    32'(bus.wsel),    32'(e_wsel));
        chk("m_wdat",    bus.wdat,         e_wdat);
        chk("m_hit1",    32'(bus.hit1),    32'(e_h1));
        chk("m_hit2",    32'(bus.hit2),    32'(e_h2));
        chk("m_hdat1",   bus.hdat1,        e_hd1);
        chk("m_hdat2",   bus.hdat2,        e_hd2);
        if (nRST) begin
            nsel = msel;
            ndat = mdat;
            if (e_wen) begin
                void'(nsel.pop_front());
                void'(ndat.pop_front());
            end
            if (bus.a_valid && e_ar && bus.a_sel != 5'd0) begin
                nsel.push_back(bus.a_sel);
                ndat.push_back(bus.a_dat);
            end
            if (bus.b_valid && e_br && bus.b_sel != 5'd0) begin
                nsel.push_back(bus.b_sel);
                ndat.push_back(bus.b_dat);
            end
            pend = 1'b1;
        end
    end

    always @(posedge CLK) begin
        if (nRST && pend) begin
            msel = nsel;
            mdat = ndat;
        end
        pend = 1'b0;
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.a_valid = 1'b0; bus.a_sel = 5'd0; bus.a_dat = 32'd0;
        bus.b_valid = 1'b0; bus.b_sel = 5'd0; bus.b_dat = 32'd0;
        bus.drain_en = 1'b0; bus.rsel1 = 5'd0; bus.rsel2 = 5'd0;
    endtask

    task automatic drain_out();
        bus.drain_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!bus.WEN) break;
            cyc();
        end
        #1;
        chk("drain_empty", 32'(bus.WEN), 32'd0);
        bus.drain_en = 1'b0;
    endtask

    initial begin
        nRST = 1'b0;
        idle();
        #5;
        chk("rst_WEN",     32'(bus.WEN),     32'd0);
        chk("rst_wdat",    bus.wdat,         32'd0);
        chk("rst_a_ready", 32'(bus.a_ready), 32'd1);
        chk("rst_b_ready", 32'(bus.b_ready), 32'd1);
        chk("rst_hit1",    32'(bus.hit1),    32'd0);
        cyc();
        nRST = 1'b1;
        cyc();

        // Single write
        bus.a_valid = 1'b1; bus.a_sel = 5'd5; bus.a_dat = 32'hDEADBEEF; bus.drain_en = 1'b1;
        #1 chk("single_a_ready", 32'(bus.a_ready), 32'd1);
        cyc();
        bus.a_valid = 1'b0;
        #1;
        chk("single_WEN",  32'(bus.WEN),  32'd1);
        chk("single_wsel", 32'(bus.wsel), 32'd5);
        chk("single_wdat", bus.wdat,      32'hDEADBEEF);
        cyc();
        #1 chk("single_WEN_after", 32'(bus.WEN), 32'd0);

        // Dual enqueue, A older than B
        idle();
        bus.a_valid = 1'b1; bus.a_sel = 5'd3; bus.a_dat = 32'h11;
        bus.b_valid = 1'b1; bus.b_sel = 5'd3; bus.b_dat = 32'h22;
        bus.rsel1 = 5'd3;
        #1;
        chk("dual_b_ready", 32'(bus.b_ready), 32'd1);
        chk("dual_no_same_cycle_hit", 32'(bus.hit1), 32'd0);
        cyc();
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        #1;
        chk("dual_hit1", 32'(bus.hit1), 32'd1);
`ifdef WB_FORWARD_EN
        chk("dual_hdat1", bus.hdat1, 32'h22);
`else
        chk("dual_hdat1_tied", bus.hdat1, 32'h0);
`endif
        chk("dual_WEN_held", 32'(bus.WEN), 32'd0);
        bus.drain_en = 1'b1;
        #1 chk("dual_first", bus.wdat, 32'h11);
        cyc();
        #1 chk("dual_second", bus.wdat, 32'h22);
        cyc();
        #1 chk("dual_done", 32'(bus.WEN), 32'd0);

        // Fill and back-pressure
        idle();
        for (int i = 1; i <= 4; i++) begin
            bus.a_valid = 1'b1; bus.a_sel = 5'(i); bus.a_dat = 32'h100 + 32'(i);
            cyc();
        end
        bus.a_valid = 1'b0;
        #1;
        chk("full_a_ready", 32'(bus.a_ready), 32'd0);
        chk("full_b_ready", 32'(bus.b_ready), 32'd0);
        bus.drain_en = 1'b1;
        #1 chk("full_pop_wsel", 32'(bus.wsel), 32'd1);
        cyc();
        bus.drain_en = 1'b0;
        #1 chk("reopen_a_ready", 32'(bus.a_ready), 32'd1);
        bus.a_valid = 1'b1; bus.a_sel = 5'd7; bus.a_dat = 32'h700;
        bus.b_valid = 1'b1; bus.b_sel = 5'd8; bus.b_dat = 32'h800;
        #1 chk("b_waits_for_a", 32'(bus.b_ready), 32'd0);
        cyc();
        bus.a_valid = 1'b0;
        #1 chk("b_waits_full", 32'(bus.b_ready), 32'd0);
        bus.drain_en = 1'b1;
        cyc();
        #1 chk("b_ready_after_pop", 32'(bus.b_ready), 32'd1);
        cyc();
        bus.b_valid = 1'b0;
        #1 chk("order_0", 32'(bus.wsel), 32'd4);
        cyc();
        #1 chk("order_1", 32'(bus.wsel), 32'd7);
        cyc();
        #1 chk("order_2", bus.wdat, 32'h800);
        cyc();
        #1 chk("order_empty", 32'(bus.WEN), 32'd0);

        // Writes to r0 are dropped
        idle();
        bus.a_valid = 1'b1; bus.a_sel = 5'd0; bus.a_dat = 32'hFFFFFFFF; bus.drain_en = 1'b1;
        #1 chk("zero_a_ready", 32'(bus.a_ready), 32'd1);
        cyc();
        bus.a_valid = 1'b0;
        #1;
        chk("zero_WEN",  32'(bus.WEN),  32'd0);
        chk("zero_hit1", 32'(bus.hit1), 32'd0);

        // Patterned traffic to wrap the pointers several times
        idle();
        for (int i = 0; i < 40; i++) begin
            bus.a_valid  = (i % 3) != 0;
            bus.a_sel    = 5'(i);
            bus.a_dat    = 32'(i) * 32'h01010101;
            bus.b_valid  = (i % 2) == 1;
            bus.b_sel    = 5'((i * 7) % 32);
            bus.b_dat    = 32'hB000_0000 + 32'(i);
            bus.drain_en = (i % 4) != 1;
            bus.rsel1    = 5'((i * 3) % 32);
            bus.rsel2    = 5'(i % 8);
            cyc();
        end
        idle();
        drain_out();

        // Reset mid-operation
        for (int i = 0; i < 3; i++) begin
            bus.a_valid = 1'b1; bus.a_sel = 5'(9 + i); bus.a_dat = 32'hC0 + 32'(i);
            cyc();
        end
        bus.a_valid = 1'b0; bus.rsel1 = 5'd10; bus.drain_en = 1'b1;
        #1 chk("pre_rst_hit1", 32'(bus.hit1), 32'd1);
        nRST = 1'b0;
        #1;
        chk("mid_rst_WEN",     32'(bus.WEN),     32'd0);
        chk("mid_rst_wsel",    32'(bus.wsel),    32'd0);
        chk("mid_rst_hit1",    32'(bus.hit1),    32'd0);
        chk("mid_rst_a_ready", 32'(bus.a_ready), 32'd1);
        chk("mid_rst_b_ready", 32'(bus.b_ready), 32'd1);
        #1 nRST = 1'b1;
        cyc();
        #1 chk("post_rst_WEN0", 32'(bus.WEN), 32'd0);
        cyc();
        #1 chk("post_rst_WEN1", 32'(bus.WEN), 32'd0);

        idle();
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
